// File: rtl/bp_cfg_loader.sv
// bp_cfg_loader: after a start, snapshots a configuration table and writes
// every field into every core's configuration registers (core-major order),
// then optionally reads each register back and compares it against the
// snapshot, recording the first mismatch.
module bp_cfg_loader #(
    parameter int num_core_p   = 2,
    parameter int num_fields_p = 16,
    parameter int data_width_p = 64,
    parameter int addr_width_p = 8,
    parameter int verify_p     = 1
) (
    input  logic                                                 clk_i,
    input  logic                                                 reset_i,
    input  logic                                                 start_i,
    input  logic [num_fields_p*data_width_p-1:0]                 cfg_data_i,
    output logic                                                 cfg_v_o,
    output logic                                                 cfg_w_o,
    output logic [((num_core_p > 1) ? $clog2(num_core_p) : 1)-1:0] cfg_core_id_o,
    output logic [addr_width_p-1:0]                              cfg_addr_o,
    output logic [data_width_p-1:0]                              cfg_data_o,
    input  logic                                                 cfg_ready_i,
    input  logic                                                 resp_v_i,
    input  logic [data_width_p-1:0]                              resp_data_i,
    output logic                                                 resp_ready_o,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic                                                 error_o,
    output logic [((num_core_p > 1) ? $clog2(num_core_p) : 1)-1:0] error_core_o,
    output logic [addr_width_p-1:0]                              error_addr_o
);

    localparam int core_w_lp  = (num_core_p > 1) ? $clog2(num_core_p) : 1;
    localparam int field_w_lp = (num_fields_p > 1) ? $clog2(num_fields_p) : 1;

    localparam logic [core_w_lp-1:0]  last_core_lp  = core_w_lp'(num_core_p - 1);
    localparam logic [field_w_lp-1:0] last_field_lp = field_w_lp'(num_fields_p - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT_RESP,
        S_DONE
    } state_e;

    state_e                  state_q, state_n;
    logic [core_w_lp-1:0]    core_q;
    logic [field_w_lp-1:0]   field_q;
    logic [data_width_p-1:0] snap_q [num_fields_p];

    logic                    error_q;
    logic [core_w_lp-1:0]    error_core_q;
    logic [field_w_lp-1:0]   error_field_q;

    logic load;       // take snapshot, clear counters and error capture
    logic advance;    // step core/field counters
    logic last_pair;  // counters point at the final core/field pair
    logic mismatch;   // readback differs from the snapshot
    logic req_active;

    assign last_pair = (core_q == last_core_lp) && (field_q == last_field_lp);
    assign mismatch  = (state_q == S_WAIT_RESP) && resp_v_i &&
                       (resp_data_i != snap_q[field_q]);

    // State register, counters and first-mismatch capture
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of every other flop, independent of order.
        if (reset_i) begin
            state_q       <= S_IDLE;
            core_q        <= '0;
            field_q       <= '0;
            error_q       <= 1'b0;
            error_core_q  <= '0;
            error_field_q <= '0;
        end else begin
            state_q <= state_n;

            if (load) begin
                core_q  <= '0;
                field_q <= '0;
            end else if (advance) begin
                if (field_q == last_field_lp) begin
                    field_q <= '0;
                    core_q  <= (core_q == last_core_lp) ? '0 : core_q + 1'b1;
                end else begin
                    field_q <= field_q + 1'b1;
                end
            end

            if (load) begin
                error_q       <= 1'b0;
                error_core_q  <= '0;
                error_field_q <= '0;
            end else if (mismatch && !error_q) begin
                error_q       <= 1'b1;
                error_core_q  <= core_q;
                error_field_q <= field_q;
            end
        end
    end

    // Snapshot of the configuration table taken at start
    always_ff @(posedge clk_i) begin
        // NOTE: the snapshot array has no reset; it is always rewritten by a
        // start before any of its entries reach an output or a comparison.
        if (load) begin
            for (int f = 0; f < num_fields_p; f++) begin
                snap_q[f] <= cfg_data_i[f*data_width_p +: data_width_p];
            end
        end
    end

    // Next-state logic and handshake controls
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path through the case statement can infer a latch.
        state_n      = state_q;
        load         = 1'b0;
        advance      = 1'b0;
        cfg_v_o      = 1'b0;
        cfg_w_o      = 1'b0;
        resp_ready_o = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_n = S_WRITE;
                end
            end
            S_WRITE: begin
                cfg_v_o = 1'b1;
                cfg_w_o = 1'b1;
                if (cfg_ready_i) begin
                    advance = 1'b1;
                    if (last_pair) begin
                        state_n = (verify_p != 0) ? S_READ : S_DONE;
                    end
                end
            end
            S_READ: begin
                cfg_v_o = 1'b1;
                if (cfg_ready_i) begin
                    state_n = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                resp_ready_o = 1'b1;
                if (resp_v_i) begin
                    advance = 1'b1;
                    state_n = last_pair ? S_DONE : S_READ;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Request payload is forced to zero whenever no request is being offered
    always_comb begin
        req_active    = (state_q == S_WRITE) || (state_q == S_READ);
        cfg_core_id_o = req_active ? core_q : '0;
        cfg_addr_o    = req_active ? addr_width_p'(field_q) : '0;
        cfg_data_o    = (state_q == S_WRITE) ? snap_q[field_q] : '0;
    end

    assign busy_o       = (state_q == S_WRITE) || (state_q == S_READ) ||
                          (state_q == S_WAIT_RESP);
    assign done_o       = (state_q == S_DONE);
    assign error_o      = error_q;
    assign error_core_o = error_core_q;
    assign error_addr_o = addr_width_p'(error_field_q);

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Directed bench for bp_cfg_loader: one instance without verify (write-only
// loads, stalls, snapshot, restart, reset) and one with verify (readback,
// mismatch capture, error clear on restart).
module tb_bp_cfg_loader;

    localparam int nc = 2;
    localparam int nf = 4;
    localparam int dw = 16;
    localparam int aw = 8;

    logic clk = 1'b0;
    logic reset_i = 1'b1;

    always #5 clk = ~clk;

    // write-only instance signals
    logic           start0 = 1'b0, ready0 = 1'b1;
    logic [nf*dw-1:0] data0 = '0;
    logic           v0, w0, rr0, busy0, done0, err0;
    logic [0:0]     core0, errc0;
    logic [aw-1:0]  addr0, erra0;
    logic [dw-1:0]  dout0;

    // verify instance signals
    logic           start1 = 1'b0, ready1 = 1'b1, resp_v1 = 1'b0;
    logic [dw-1:0]  resp_d1 = '0;
    logic [nf*dw-1:0] data1 = '0;
    logic           v1, w1, rr1, busy1, done1, err1;
    logic [0:0]     core1, errc1;
    logic [aw-1:0]  addr1, erra1;
    logic [dw-1:0]  dout1;

    bp_cfg_loader #(.num_core_p(nc), .num_fields_p(nf), .data_width_p(dw),
                    .addr_width_p(aw), .verify_p(0)) u0 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start0), .cfg_data_i(data0),
        .cfg_v_o(v0), .cfg_w_o(w0), .cfg_core_id_o(core0), .cfg_addr_o(addr0),
        .cfg_data_o(dout0), .cfg_ready_i(ready0), .resp_v_i(1'b0),
        .resp_data_i({dw{1'b0}}), .resp_ready_o(rr0), .busy_o(busy0),
        .done_o(done0), .error_o(err0), .error_core_o(errc0), .error_addr_o(erra0)
    );

    bp_cfg_loader #(.num_core_p(nc), .num_fields_p(nf), .data_width_p(dw),
                    .addr_width_p(aw), .verify_p(1)) u1 (
        .clk_i(clk), .reset_i(reset_i), .start_i(start1), .cfg_data_i(data1),
        .cfg_v_o(v1), .cfg_w_o(w1), .cfg_core_id_o(core1), .cfg_addr_o(addr1),
        .cfg_data_o(dout1), .cfg_ready_i(ready1), .resp_v_i(resp_v1),
        .resp_data_i(resp_d1), .resp_ready_o(rr1), .busy_o(busy1),
        .done_o(done1), .error_o(err1), .error_core_o(errc1), .error_addr_o(erra1)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; outputs are then observed 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Table A: field f = 0x10+f ; table B: field f = 0x20+f
    localparam logic [nf*dw-1:0] tab_a = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    localparam logic [nf*dw-1:0] tab_b = {16'h0023, 16'h0022, 16'h0021, 16'h0020};

    // Full verified load on u1; responses echo written data one cycle after
    // the read handshake except at the two given pair indices (-1 = none).
    task automatic run_verify(input int bad_a, input int bad_b,
                              input logic exp_err, input logic exp_core,
                              input logic [aw-1:0] exp_addr);
        logic [dw-1:0] mem [nc*nf];
        int nw, nr, cyc, pidx;
        logic pend;
        nw = 0; nr = 0; cyc = 0; pend = 1'b0; pidx = 0;
        for (int i = 0; i < nc*nf; i++) mem[i] = '0;
        resp_v1 = 1'b0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("v_err_cleared", 64'(err1), 64'd0);
        check("v_first_req", 64'(v1), 64'd1);
        while (done1 !== 1'b1 && cyc < 100) begin
            resp_v1 = pend;
            resp_d1 = '0;
            if (pend) begin
                if (pidx == bad_a)      resp_d1 = 16'hDEAD;
                else if (pidx == bad_b) resp_d1 = mem[pidx] ^ 16'hFFFF;
                else                    resp_d1 = mem[pidx];
            end
            pend = 1'b0;
            if (v1 && w1) begin
                if (nw < nc*nf) begin
                    check("v_wr_core", 64'(core1), 64'(nw / nf));
                    check("v_wr_addr", 64'(addr1), 64'(nw % nf));
                    check("v_wr_data", 64'(dout1), 64'(16'h10 + nw % nf));
                end
                mem[int'(core1)*nf + int'(addr1)] = dout1;
                nw++;
            end else if (v1 && !w1) begin
                if (nr < nc*nf) begin
                    check("v_rd_core", 64'(core1), 64'(nr / nf));
                    check("v_rd_addr", 64'(addr1), 64'(nr % nf));
                end
                pidx = int'(core1)*nf + int'(addr1);
                pend = 1'b1;
                nr++;
            end
            tick();
            cyc++;
        end
        resp_v1 = 1'b0;
        check("v_done", 64'(done1), 64'd1);
        check("v_busy_low", 64'(busy1), 64'd0);
        check("v_nwrites", 64'(nw), 64'(nc*nf));
        check("v_nreads", 64'(nr), 64'(nc*nf));
        check("v_error", 64'(err1), 64'(exp_err));
        check("v_err_core", 64'(errc1), 64'(exp_core));
        check("v_err_addr", 64'(erra1), 64'(exp_addr));
    endtask

    initial begin
        int k, cyc;
        data0 = tab_a;
        data1 = tab_a;

        // reset state
        tick(); tick();
        reset_i = 1'b0;
        check("rst_v0", 64'(v0), 64'd0);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_v1", 64'(v1), 64'd0);
        check("rst_err1", 64'(err1), 64'd0);

        // 8 back-to-back writes, done at cycle 9 after start
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < nc*nf; i++) begin
            check("w_v", 64'(v0), 64'd1);
            check("w_w", 64'(w0), 64'd1);
            check("w_core", 64'(core0), 64'(i / nf));
            check("w_addr", 64'(addr0), 64'(i % nf));
            check("w_data", 64'(dout0), 64'(16'h10 + i % nf));
            check("w_busy", 64'(busy0), 64'd1);
            tick();
        end
        check("w_done", 64'(done0), 64'd1);
        check("w_busy_low", 64'(busy0), 64'd0);
        check("w_v_low", 64'(v0), 64'd0);

        // restart from DONE with ready toggling 1-0-1-0
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        k = 0; cyc = 0;
        while (k < nc*nf && cyc < 40) begin
            ready0 = (cyc % 2 == 0);
            check("s_v", 64'(v0), 64'd1);
            check("s_core", 64'(core0), 64'(k / nf));
            check("s_addr", 64'(addr0), 64'(k % nf));
            check("s_data", 64'(dout0), 64'(16'h10 + k % nf));
            check("s_not_done", 64'(done0), 64'd0);
            tick();
            if (ready0) k++;
            cyc++;
        end
        ready0 = 1'b1;
        check("s_count", 64'(k), 64'(nc*nf));
        check("s_done", 64'(done0), 64'd1);

        // snapshot isolation and start ignored while busy
        data0 = tab_a;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        data0 = tab_b;
        for (int i = 0; i < nc*nf; i++) begin
            check("n_core", 64'(core0), 64'(i / nf));
            check("n_addr", 64'(addr0), 64'(i % nf));
            check("n_data", 64'(dout0), 64'(16'h10 + i % nf));
            start0 = (i == 3);
            tick();
        end
        start0 = 1'b0;
        check("n_done", 64'(done0), 64'd1);

        // reset during the 3rd write, then a clean restart
        data0 = tab_a;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick(); tick();
        check("r_third_addr", 64'(addr0), 64'd2);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("r_v", 64'(v0), 64'd0);
        check("r_w", 64'(w0), 64'd0);
        check("r_core", 64'(core0), 64'd0);
        check("r_addr", 64'(addr0), 64'd0);
        check("r_data", 64'(dout0), 64'd0);
        check("r_busy", 64'(busy0), 64'd0);
        check("r_done", 64'(done0), 64'd0);
        check("r_err", 64'(err0), 64'd0);
        tick();
        check("r_idle_v", 64'(v0), 64'd0);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("r2_v", 64'(v0), 64'd1);
        check("r2_core", 64'(core0), 64'd0);
        check("r2_addr", 64'(addr0), 64'd0);
        check("r2_data", 64'(dout0), 64'h10);
        for (int i = 0; i < nc*nf; i++) tick();
        check("r2_done", 64'(done0), 64'd1);

        // stray response while idle is ignored
        resp_v1 = 1'b1;
        resp_d1 = 16'hBEEF;
        tick();
        resp_v1 = 1'b0;
        check("i_rr", 64'(rr1), 64'd0);
        check("i_err", 64'(err1), 64'd0);
        check("i_busy", 64'(busy1), 64'd0);

        // verified load, clean echo
        run_verify(-1, -1, 1'b0, 1'b0, 8'd0);
        // core 1 addr 2 returns 0xDEAD, core 1 addr 3 also wrong: first kept
        run_verify(6, 7, 1'b1, 1'b1, 8'd2);
        // restart from DONE clears the error and reloads cleanly
        run_verify(-1, -1, 1'b0, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_cfg_loader.md
# bp_cfg_loader

Runtime configuration loader that pushes a selected processor configuration into every core's configuration registers after reset, optionally reading each register back to verify it. It sits between the static configuration tables and the per-core configuration links. It generalises fixed compile-time configurations with parametrised core count, field count and width, plus a verify mode. It reports completion and the first mismatch.

## Interface
- num_core_p, 2, number of target cores
- num_fields_p, 16, configuration registers per core; the register address equals the field index
- data_width_p, 64, width of each configuration field
- addr_width_p, 8, register address width; must satisfy num_fields_p <= 2^addr_width_p
- verify_p, 1, 1 enables the readback/compare phase; 0 skips it
- clk_i  input  1  clock
- reset_i  input  1  synchronous, active-high reset
- start_i  input  1  begin a load; honoured only in IDLE or DONE
- cfg_data_i  input  num_fields_p*data_width_p  field f occupies bits [f*data_width_p +: data_width_p]
- cfg_v_o  output  1  request valid
- cfg_w_o  output  1  1 = write, 0 = read
- cfg_core_id_o  output  max(1,clog2(num_core_p))  target core
- cfg_addr_o  output  addr_width_p  register address
- cfg_data_o  output  data_width_p  write data; 0 on reads
- cfg_ready_i  input  1  link accepts the request when cfg_v_o & cfg_ready_i
- resp_v_i  input  1  read response valid
- resp_data_i  input  data_width_p  read data
- resp_ready_o  output  1  loader accepts the response
- busy_o  output  1  high in WRITE, READ or WAIT_RESP
- done_o  output  1  high in DONE
- error_o  output  1  sticky mismatch flag
- error_core_o  output  same width as cfg_core_id_o  core of the first mismatch
- error_addr_o  output  addr_width_p  address of the first mismatch

## Operation
- States: IDLE, WRITE, READ, WAIT_RESP, DONE.
- IDLE or DONE with start_i=1:
  - snapshot cfg_data_i into an internal register file
  - clear error_o, error_core_o and error_addr_o
  - zero the core and field counters
  - go to WRITE
- cfg_data_i is ignored after the snapshot.
- WRITE:
  - cfg_v_o=1, cfg_w_o=1; data = snapshot[field]
  - on handshake, advance the counters in core-major order: field increments; at num_fields_p-1 it wraps to 0 and core increments
  - after the handshake at core num_core_p-1 / field num_fields_p-1, go to READ with counters zeroed if verify_p=1, else go to DONE
- READ:
  - cfg_v_o=1, cfg_w_o=0
  - on handshake, go to WAIT_RESP
  - only one read is outstanding at a time
- WAIT_RESP:
  - resp_ready_o=1 and cfg_v_o=0
  - on resp_v_i, compare resp_data_i with snapshot[field]
  - on mismatch with error_o=0: set error_o and capture core and field; later mismatches do not overwrite the capture
  - advance the counters; after the last pair go to DONE, else go to READ
- The load never aborts on error; all pairs are verified.
- DONE: hold until start_i or reset.
- resp_v_i outside WAIT_RESP is ignored (resp_ready_o=0).
- start_i while busy is ignored.

## Timing
- Reset (any state, including mid-transfer): next cycle the state is IDLE, all outputs are 0 and the counters are 0.
  - No request is issued in the cycle following reset.
  - A response that arrives after reset is ignored.
- start_i sampled at cycle t gives cfg_v_o=1 at cycle t+1.
- Write phase with cfg_ready_i held high: one write per cycle, num_core_p*num_fields_p cycles.
- Read phase: at least 2 cycles per register (request, then response). The response may come in the cycle right after the request handshake.
- Request fields stay stable while cfg_v_o=1 and cfg_ready_i=0.
- Completion timing:
  - done_o rises the cycle after the final write handshake (verify_p=0)
  - or the cycle after the final response (verify_p=1)
  - busy_o falls in that same cycle
- error_o is valid in the cycle after the offending response and holds until the next start or reset.
- Restart from DONE behaves identically to a start from IDLE.

## Test plan
- num_core_p=2, num_fields_p=4, verify_p=0, field f = 0x10+f, ready always high -> 8 writes on consecutive cycles, (core,addr,data) from (0,0,0x10) to (1,3,0x13); done_o at cycle 9 after start.
- Same config, ready toggling 1-0-1-0 -> request held stable while stalled, same 8 writes in order, done_o only after the 8th handshake.
- verify_p=1, responses echo the written data with 1-cycle latency -> 8 writes then 8 read/response pairs, error_o=0, done_o=1.
- verify_p=1, the response for core 1 addr 2 returns 0xDEAD and the response for core 1 addr 3 also mismatches -> error_o=1, error_core_o=1, error_addr_o=2 (first mismatch kept), all 8 reads still issued, done_o=1.
- reset_i pulsed during the 3rd write -> next cycle all outputs 0 and state IDLE; a fresh start_i restarts from core 0 addr 0.
- cfg_data_i changed the cycle after start_i, and start_i pulsed mid-load -> written data matches the snapshot and the second start has no effect; a start_i in DONE clears error_o and reloads.
